// File: rtl/rv_mdu_seq.sv
// Iterative RV32M multiply/divide sequencer: shift-add multiply, restoring divide, XLEN cycles.
// Optional RV_MDU_FAST_MUL_EN: single-cycle combinational multiply at accept; divides stay iterative.
module rv_mdu_seq #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk_i,
    input  logic            arstn_i,
    input  logic            mdu_req_i,
    input  logic [2:0]      mdu_op_i,
    input  logic [XLEN-1:0] mdu_port_a_i,
    input  logic [XLEN-1:0] mdu_port_b_i,
    input  logic            mdu_kill_i,
    output logic            mdu_stall_req_o,
    output logic            mdu_valid_o,
    output logic [XLEN-1:0] mdu_result_o
);

    localparam int unsigned      CNT_W   = $clog2(XLEN);
    localparam logic [XLEN-1:0]  MinNeg  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [CNT_W-1:0] CntLast = CNT_W'(XLEN-1);

    typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

    state_e            state_q;
    logic [2:0]        op_q;
    logic [XLEN-1:0]   opnd_q;
    logic [XLEN-1:0]   lo_q;
    logic [XLEN:0]     acc_q;
    logic [XLEN-1:0]   result_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              sign_q;
    logic              valid_q;

    logic              in_is_div, in_is_rem, a_signed, b_signed, a_neg, b_neg, in_sign;
    logic [XLEN-1:0]   a_mag, b_mag, fast_res;
    logic              fast_hit;

`ifdef RV_MDU_FAST_MUL_EN
    logic [2*XLEN-1:0] fm_a, fm_b, fm_prod;
    // Low 2*XLEN bits of the sign-extended product equal the (XLEN+1)x(XLEN+1) signed product.
    assign fm_a    = {{XLEN{a_neg}}, mdu_port_a_i};
    assign fm_b    = {{XLEN{b_neg}}, mdu_port_b_i};
    assign fm_prod = fm_a * fm_b;
`endif

    always_comb begin
        in_is_div = mdu_op_i[2];
        in_is_rem = mdu_op_i[2] & mdu_op_i[1];
        a_signed  = (mdu_op_i == 3'd1) | (mdu_op_i == 3'd2) | (mdu_op_i == 3'd4) |
                    (mdu_op_i == 3'd6);
        b_signed  = (mdu_op_i == 3'd1) | (mdu_op_i == 3'd4) | (mdu_op_i == 3'd6);
        a_neg     = a_signed & mdu_port_a_i[XLEN-1];
        b_neg     = b_signed & mdu_port_b_i[XLEN-1];
        a_mag     = a_neg ? -mdu_port_a_i : mdu_port_a_i;
        b_mag     = b_neg ? -mdu_port_b_i : mdu_port_b_i;
        in_sign   = in_is_rem ? a_neg : (a_neg ^ b_neg);
        fast_hit  = 1'b0;
        fast_res  = '0;
        if (in_is_div) begin
            if (mdu_port_b_i == '0) begin
                fast_hit = 1'b1;
                fast_res = in_is_rem ? mdu_port_a_i : '1;
            end else if (a_signed && (mdu_port_a_i == MinNeg) && (mdu_port_b_i == '1)) begin
                fast_hit = 1'b1;
                fast_res = in_is_rem ? '0 : MinNeg;
            end
        end
`ifdef RV_MDU_FAST_MUL_EN
        else begin
            fast_hit = 1'b1;
            fast_res = (mdu_op_i == 3'd0) ? fm_prod[XLEN-1:0] : fm_prod[2*XLEN-1:XLEN];
        end
`endif
    end

    logic [XLEN:0]     mul_sum, rem_sh, rem_diff, acc_d;
    logic [XLEN-1:0]   lo_d, fix_res;
    logic [2*XLEN-1:0] prod, prod_fix;

    always_comb begin
        mul_sum  = acc_q + (lo_q[0] ? {1'b0, opnd_q} : '0);
        rem_sh   = {acc_q[XLEN-1:0], lo_q[XLEN-1]};
        rem_diff = rem_sh - {1'b0, opnd_q};
        if (op_q[2]) begin
            // Restoring step: keep the difference only when it did not go negative.
            if (!rem_diff[XLEN]) begin
                acc_d = rem_diff;
                lo_d  = {lo_q[XLEN-2:0], 1'b1};
            end else begin
                acc_d = rem_sh;
                lo_d  = {lo_q[XLEN-2:0], 1'b0};
            end
        end else begin
            acc_d = {1'b0, mul_sum[XLEN:1]};
            lo_d  = {mul_sum[0], lo_q[XLEN-1:1]};
        end

        prod     = {acc_q[XLEN-1:0], lo_q};
        prod_fix = sign_q ? -prod : prod;
        unique case (op_q)
            3'd0:             fix_res = prod_fix[XLEN-1:0];
            3'd1, 3'd2, 3'd3: fix_res = prod_fix[2*XLEN-1:XLEN];
            3'd4, 3'd5:       fix_res = sign_q ? -lo_q : lo_q;
            default:          fix_res = sign_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
        endcase
    end

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            state_q  <= StIdle;
            op_q     <= '0;
            opnd_q   <= '0;
            lo_q     <= '0;
            acc_q    <= '0;
            result_q <= '0;
            cnt_q    <= '0;
            sign_q   <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            if (mdu_kill_i) begin
                state_q <= StIdle;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        if (mdu_req_i) begin
                            op_q   <= mdu_op_i;
                            sign_q <= in_sign;
                            cnt_q  <= '0;
                            acc_q  <= '0;
                            if (fast_hit) begin
                                result_q <= fast_res;
                                valid_q  <= 1'b1;
                                state_q  <= StDone;
                            end else begin
                                state_q <= StCalc;
                                opnd_q  <= in_is_div ? b_mag : a_mag;
                                lo_q    <= in_is_div ? a_mag : b_mag;
                            end
                        end
                    end
                    StCalc: begin
                        acc_q <= acc_d;
                        lo_q  <= lo_d;
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == CntLast) state_q <= StFix;
                    end
                    StFix: begin
                        result_q <= fix_res;
                        valid_q  <= 1'b1;
                        state_q  <= StDone;
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    assign mdu_valid_o     = valid_q;
    assign mdu_result_o    = result_q;
    assign mdu_stall_req_o = mdu_req_i & ~valid_q;

endmodule
